// File: rtl/pipe_sequencer_pkg.sv
// Shared constants and types for the ARM front-end sequencer:
// ctrl vector layout, PC increment, bubble word and stage bundle.
package pipe_sequencer_pkg;

    localparam int CTRL_VECTOR_SIZE = 16;

    localparam int EXEC_THIS    = 0;
    localparam int INST_TYPE_LO = 1;
    localparam int INST_TYPE_HI = 3;
    localparam int READ_REGA_LO = 4;
    localparam int READ_REGA_HI = 7;
    localparam int READ_REGB_LO = 8;
    localparam int READ_REGB_HI = 11;
    localparam int WRITE_REG_LO = 12;
    localparam int WRITE_REG_HI = 15;

    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [2:0] {
        ITYPE_NONE   = 3'd0,
        ITYPE_DP     = 3'd1,
        ITYPE_MEM    = 3'd2,
        ITYPE_BRANCH = 3'd3,
        ITYPE_BLOCK  = 3'd4,
        ITYPE_SYS    = 3'd5
    } itype_e;

    typedef logic [CTRL_VECTOR_SIZE-1:0] ctrl_t;

    typedef struct packed {
        logic [31:0] inst;
        ctrl_t       ctrl;
    } stage_t;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Fetch, hazard and stage-register bundle between the sequencer
// (master) and the datapath / instruction memory side (slave).
interface pipe_sequencer_if;
    import pipe_sequencer_pkg::*;

    logic [31:0] inst_mem_data;
    logic [31:0] inst_mem_addr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_curr;
    logic [31:0] decd_inst;
    logic [31:0] exec_inst;
    logic [31:0] memw_inst;
    logic [31:0] wrbk_inst;
    ctrl_t       decd_ctrl;
    ctrl_t       exec_ctrl;
    ctrl_t       memw_ctrl;
    ctrl_t       wrbk_ctrl;

    modport master (
        input  inst_mem_data, stall, branch_taken, branch_target,
        output inst_mem_addr, pc_curr,
        output decd_inst, exec_inst, memw_inst, wrbk_inst,
        output decd_ctrl, exec_ctrl, memw_ctrl, wrbk_ctrl
    );

    modport slave (
        output inst_mem_data, stall, branch_taken, branch_target,
        input  inst_mem_addr, pc_curr,
        input  decd_inst, exec_inst, memw_inst, wrbk_inst,
        input  decd_ctrl, exec_ctrl, memw_ctrl, wrbk_ctrl
    );

endinterface

// File: rtl/pipe_sequencer_inst_decoder.sv
// Combinational decoder: instruction word + valid -> ctrl vector.
// Condition codes are treated as always passing.
module pipe_sequencer_inst_decoder
    import pipe_sequencer_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        valid,
    output ctrl_t       ctrl
);

    itype_e itype;
    logic   field_unused;

    assign field_unused = ^{inst[31:28], inst[24:20], inst[11:4]};

    always_comb begin
        itype = ITYPE_SYS;
        unique case (1'b1)
            inst[27:26] == 2'b00:  itype = ITYPE_DP;
            inst[27:26] == 2'b01:  itype = ITYPE_MEM;
            inst[27:25] == 3'b101: itype = ITYPE_BRANCH;
            inst[27:25] == 3'b100: itype = ITYPE_BLOCK;
            inst[27:26] == 2'b11:  itype = ITYPE_SYS;
        endcase
    end

    // A bubble yields an all-zero vector so nothing downstream acts on it.
    always_comb begin
        ctrl = '0;
        if (valid) begin
            ctrl[EXEC_THIS]                   = 1'b1;
            ctrl[INST_TYPE_HI:INST_TYPE_LO]   = itype;
            ctrl[READ_REGA_HI:READ_REGA_LO]   = inst[19:16];
            ctrl[READ_REGB_HI:READ_REGB_LO]   = inst[3:0];
            ctrl[WRITE_REG_HI:WRITE_REG_LO]   = inst[15:12];
        end
    end

endmodule

// File: rtl/pipe_sequencer.sv
// PC / stage-register sequencer for the 5-stage ARM pipe.
// Optional PIPE_PERF_CNT_EN adds cycle/retire/stall counters.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic clk,
    input  logic reset,
    pipe_sequencer_if.master bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stalls
`endif
);

    logic [31:0] pc;
    logic [31:0] decd_inst;
    logic        decd_valid;
    ctrl_t       decd_ctrl;
    stage_t      exec_q;
    stage_t      memw_q;
    stage_t      wrbk_q;
    logic        tgt_unused;

    assign tgt_unused = ^bus.branch_target[1:0];

    pipe_sequencer_inst_decoder inst_decoder (
        .inst  (decd_inst),
        .valid (decd_valid),
        .ctrl  (decd_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= RESET_PC;
            decd_inst  <= NOP_INST;
            decd_valid <= 1'b0;
            exec_q     <= '0;
            memw_q     <= '0;
            wrbk_q     <= '0;
        end else begin
            memw_q <= exec_q;
            wrbk_q <= memw_q;
            // Branch beats stall: the stalled decd word is wrong-path.
            if (bus.branch_taken) begin
                pc         <= {bus.branch_target[31:2], 2'b00};
                decd_inst  <= NOP_INST;
                decd_valid <= 1'b0;
                exec_q     <= '0;
            end else if (bus.stall) begin
                exec_q     <= '0;
            end else begin
                pc         <= pc + PC_INCR;
                decd_inst  <= bus.inst_mem_data;
                decd_valid <= 1'b1;
                exec_q     <= '{inst: decd_inst, ctrl: decd_ctrl};
            end
        end
    end

    assign bus.inst_mem_addr = pc;
    assign bus.pc_curr       = pc;
    assign bus.decd_inst     = decd_inst;
    assign bus.decd_ctrl     = decd_ctrl;
    assign bus.exec_inst     = exec_q.inst;
    assign bus.exec_ctrl     = exec_q.ctrl;
    assign bus.memw_inst     = memw_q.inst;
    assign bus.memw_ctrl     = memw_q.ctrl;
    assign bus.wrbk_inst     = wrbk_q.inst;
    assign bus.wrbk_ctrl     = wrbk_q.ctrl;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
            perf_stalls  <= '0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (wrbk_q.ctrl[EXEC_THIS])
                perf_retired <= perf_retired + 32'd1;
            if (bus.stall && !bus.branch_taken)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Front-end sequencer for the 5-stage ARM pipeline. It owns the program counter, fetches from instruction memory, and shifts instruction words and control vectors through the decode, execute, memory and writeback stage registers. It feeds `datapath` its `pc_curr`, `*_inst` and `*_ctrl` inputs, applies `datapath`'s `stall` by inserting bubbles, and flushes on taken branches. Control vectors are produced by the `inst_decoder` sub-module.

## Interface
Parameters
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports (`clk` and `reset` share one clock domain; reset is synchronous and active-low)
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-low. `reset==0` at a posedge resets the block.
- inst_mem_data  input  32  instruction word at `inst_mem_addr`, combinational, same cycle.
- stall  input  1  from `datapath`; load-use hazard between decode and execute.
- branch_taken  input  1  branch in execute resolved taken this cycle; only valid when `exec_ctrl[EXEC_THIS]` is set.
- branch_target  input  32  byte address of the taken branch destination.
- inst_mem_addr  output  32  fetch address, equal to `pc_curr`.
- pc_curr  output  32  PC of the instruction being fetched.
- decd_inst, exec_inst, memw_inst, wrbk_inst  output  32 each  stage instruction words.
- decd_ctrl, exec_ctrl, memw_ctrl, wrbk_ctrl  output  `CTRL_VECTOR_SIZE` each  stage control vectors.

## Operation
- Fetch: `inst_mem_addr = pc_curr`. Normal advance: `pc_curr <= pc_curr + PC_INCR` (4), with 32-bit wrap from FFFF_FFFC to 0.
- `decd_ctrl` is combinational, from `inst_decoder(decd_inst)`. The exec, memw and wrbk ctrl/inst registers are flops.
- Normal cycle: fetched word → decd; decd → exec; exec → memw; memw → wrbk.
- A bubble is inst = 32'h0 with EXEC_THIS = 0. `inst_decoder` forces EXEC_THIS = 0 for a decd bubble; this is tracked by an internal `decd_valid` flop.
- Stall (`stall==1`, `branch_taken==0`):
  - `pc_curr` and the decd register hold.
  - exec receives a bubble.
  - memw and wrbk advance.
- Taken branch (`branch_taken==1`):
  - `pc_curr <= branch_target`.
  - decd receives a bubble, killing the wrong-path fetch.
  - exec receives a bubble, killing the wrong-path decd instruction.
  - memw receives the branch; wrbk advances.
- Priority: reset > branch_taken > stall > normal. When branch and stall coincide, the stall is discarded, because the stalled decd instruction is on the wrong path.
- Conditional execution: `inst_decoder` evaluates the condition field against an `flags` input; this is out of scope here and is tied true (EXEC_THIS reflects valid only).

## Timing
- Reset values:
  - `pc_curr` = RESET_PC.
  - All `*_inst` = 0.
  - All EXEC_THIS = 0; other ctrl fields are don't-care but driven 0.
  - Counters = 0.
- First fetch is at RESET_PC in the cycle after `reset` rises to 1. That instruction is in decd one cycle later and in wrbk four cycles later.
- Latency is fetch→decd 1, decd→exec 1, exec→memw 1, memw→wrbk 1.
- Load-use stall costs 1 bubble per cycle that `stall` stays high.
- Taken-branch penalty is 2 bubbles. The target is fetched in cycle t+1, is in decd at t+2, and in exec at t+3.
- Reset mid-operation: all in-flight instructions are discarded at that edge, with no partial writeback.
- `branch_target` is used as given; the low 2 bits are forced to 0.

## Configuration
- `PIPE_PERF_CNT_EN` defined adds three 32-bit output counters, each wrapping at 2^32:
  - `perf_cycles` increments every non-reset cycle.
  - `perf_retired` increments when `wrbk_ctrl[EXEC_THIS]` is set.
  - `perf_stalls` increments when `stall && !branch_taken`.
- `PIPE_PERF_CNT_EN` undefined: the ports and logic are absent.

## Structure
- `arm_constants.v` supplies `CTRL_VECTOR_SIZE`, the ctrl field ranges (`EXEC_THIS`, `INST_TYPE`, `READ_REGA/B`, `WRITE_REG`), `PC_INCR`, and the instruction-type codes. It also gains a `NOP_INST` (32'h0) constant.
- Sub-module `inst_decoder` is purely combinational and maps a 32-bit instruction plus valid to a ctrl vector. It is instantiated once, on decd.

## Test plan
- Reset held low 3 cycles, then released: `pc_curr` = 0, 4, 8 on successive cycles; wrbk EXEC_THIS first goes to 1 four cycles after the first fetch.
- Straight-line code at 0x00..0x10: each word appears in exec exactly 2 cycles after its fetch, with `inst` values matching.
- `stall` high 1 cycle while decd holds an ADD at PC 8: `pc_curr` holds at 12, exec shows a bubble, and the ADD enters exec the following cycle.
- `branch_taken` with target 0x100 while the branch is in exec: the next two exec slots are bubbles, `pc_curr` = 0x100 then 0x104, and the word from 0x100 is in exec at t+3.
- `branch_taken` and `stall` asserted together with target 0x40: the branch path is taken, `pc_curr` = 0x40, and the stalled decd instruction never reaches memw.
- Reset pulsed low mid-stream, and separately with `PIPE_PERF_CNT_EN` defined: a 10-cycle run with 1 stall and 6 retires gives counters 10/6/1, and all EXEC_THIS clear at the reset edge.
